cdb_arbiter: RTL and testbench

Parametrised common data bus for the Tomasulo core. It collects completed results from NUM_SRC functional-unit channels (add, logic, mul, load, store, …). Each cycle it grants exactly one pending request by round-robin and broadcasts that request's tag and value to the reservation stations and register status one cycle later. It uses a synchronous valid/grant handshake with no intra-cycle delays, so it replaces the serial, delay-based bus with a fair, fully clocked one.

---
 rtl/cdb_arbiter.sv | 158 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common data bus for the Tomasulo core. Completed results from NUM_SRC
// functional-unit channels compete for the bus. Every cycle one pending
// channel is granted by round-robin, and its tag and value are broadcast
// from registers in the following cycle.
//
// Optional feature macro: CDB_TAG_CHECK_EN
//   When defined, a winning request whose tag equals INVALID_TAG is consumed
//   but not broadcast, and the sticky out_tag_err flag is raised.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_request    per-channel request, held high until granted
//   in_tag        packed channel tags, channel i at [i*TAG_W +: TAG_W]
//   in_val        packed channel values, channel i at [i*DATA_W +: DATA_W]
//   out_grant     combinational one-hot grant (all-zero when idle or in reset)
//   out_broadcast registered, high for one cycle per accepted result
//   out_tag       registered broadcast tag (INVALID_TAG when idle)
//   out_val       registered broadcast value (holds while idle)
//   out_tag_err   sticky invalid-tag error (CDB_TAG_CHECK_EN only)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int                NUM_SRC     = 5,
    parameter int                TAG_W       = 5,
    parameter int                DATA_W      = 32,
    parameter logic [TAG_W-1:0]  INVALID_TAG = {TAG_W{1'b1}},
    localparam int               PTR_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        in_request,
    input  logic [NUM_SRC*TAG_W-1:0]  in_tag,
    input  logic [NUM_SRC*DATA_W-1:0] in_val,
    output logic [NUM_SRC-1:0]        out_grant,
    output logic                      out_broadcast,
    output logic [TAG_W-1:0]          out_tag,
    output logic [DATA_W-1:0]         out_val
`ifdef CDB_TAG_CHECK_EN
    ,
    output logic                      out_tag_err
`endif
);

    logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
    logic              outBroadcast_q, outBroadcast_d;
    logic [TAG_W-1:0]  outTag_q, outTag_d;
    logic [DATA_W-1:0] outVal_q, outVal_d;
`ifdef CDB_TAG_CHECK_EN
    logic              tagErr_q, tagErr_d;
`endif

    logic              winValid;
    logic [PTR_W-1:0]  winIdx;
    logic [PTR_W:0]    candIdx;
    logic [TAG_W-1:0]  winTag;
    logic [DATA_W-1:0] winVal;

    // Round-robin search: walk the channels starting at rrPtr_q, wrapping
    // past NUM_SRC-1 back to 0, and keep the first pending one. The extra
    // bit on candIdx lets the sum exceed NUM_SRC before it is folded back.
    // Reset suppresses the winner so nothing is granted while rst_n is low.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            candIdx = {1'b0, rrPtr_q} + (PTR_W+1)'(k);
            if (candIdx >= (PTR_W+1)'(NUM_SRC)) begin
                candIdx = candIdx - (PTR_W+1)'(NUM_SRC);
            end
            if (!winValid && in_request[candIdx[PTR_W-1:0]]) begin
                winValid = 1'b1;
                winIdx   = candIdx[PTR_W-1:0];
            end
        end
        if (!rst_n) begin
            winValid = 1'b0;
        end
    end

    // Turn the winning index into the one-hot grant and pull the winner's
    // tag and value out of the packed input buses.
    always_comb begin
        out_grant = '0;
        winTag    = INVALID_TAG;
        winVal    = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (winValid && (winIdx == PTR_W'(j))) begin
                out_grant[j] = 1'b1;
                winTag       = in_tag[j*TAG_W +: TAG_W];
                winVal       = in_val[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the pointer and broadcast registers. An idle edge
    // drives the invalid tag and keeps the last value; a grant moves the
    // pointer just past the winner so it drops to lowest priority.
    always_comb begin
        rrPtr_d        = rrPtr_q;
        outBroadcast_d = 1'b0;
        outTag_d       = INVALID_TAG;
        outVal_d       = outVal_q;
`ifdef CDB_TAG_CHECK_EN
        tagErr_d       = tagErr_q;
`endif
        if (winValid) begin
            rrPtr_d = (winIdx == PTR_W'(NUM_SRC-1)) ? '0 : winIdx + PTR_W'(1);
`ifdef CDB_TAG_CHECK_EN
            if (winTag == INVALID_TAG) begin
                tagErr_d = 1'b1;
            end else begin
                outBroadcast_d = 1'b1;
                outTag_d       = winTag;
                outVal_d       = winVal;
            end
`else
            outBroadcast_d = 1'b1;
            outTag_d       = winTag;
            outVal_d       = winVal;
`endif
        end
    end

    // State registers with synchronous reset. A request pending at the reset
    // edge is simply not captured, so it will be arbitrated again from
    // pointer 0 once reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr_q        <= '0;
            outBroadcast_q <= 1'b0;
            outTag_q       <= INVALID_TAG;
            outVal_q       <= '0;
`ifdef CDB_TAG_CHECK_EN
            tagErr_q       <= 1'b0;
`endif
        end else begin
            rrPtr_q        <= rrPtr_d;
            outBroadcast_q <= outBroadcast_d;
            outTag_q       <= outTag_d;
            outVal_q       <= outVal_d;
`ifdef CDB_TAG_CHECK_EN
            tagErr_q       <= tagErr_d;
`endif
        end
    end

    assign out_broadcast = outBroadcast_q;
    assign out_tag       = outTag_q;
    assign out_val       = outVal_q;
`ifdef CDB_TAG_CHECK_EN
    assign out_tag_err   = tagErr_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter with default parameters. A small
// round-robin model predicts the grant each cycle and pushes the expected
// bus contents onto a scoreboard at every clock edge; the entry is popped
// and compared at the following falling edge. Builds with or without
// CDB_TAG_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_SRC = 5;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;
    localparam logic [TAG_W-1:0] INV = 5'h1F;

    typedef struct packed {
        logic              bcast;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        in_request;
    logic [NUM_SRC*TAG_W-1:0]  in_tag;
    logic [NUM_SRC*DATA_W-1:0] in_val;
    logic [NUM_SRC-1:0]        out_grant;
    logic                      out_broadcast;
    logic [TAG_W-1:0]          out_tag;
    logic [DATA_W-1:0]         out_val;
`ifdef CDB_TAG_CHECK_EN
    logic                      out_tag_err;
`endif

    exp_t              sbq[$];
    int                compared   = 0;
    int                mismatched = 0;
    int                ptrModel   = 0;
    logic [DATA_W-1:0] lastVal    = '0;
    logic              errModel   = 1'b0;

    cdb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_request    (in_request),
        .in_tag        (in_tag),
        .in_val        (in_val),
        .out_grant     (out_grant),
        .out_broadcast (out_broadcast),
        .out_tag       (out_tag),
        .out_val       (out_val)
`ifdef CDB_TAG_CHECK_EN
        ,
        .out_tag_err   (out_tag_err)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model winner: first pending channel scanning from the model pointer.
    function automatic int modelWinner();
        int idx;
        if (!rst_n) return -1;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (ptrModel + k) % NUM_SRC;
            if (in_request[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_SRC-1:0] modelGrant();
        int w;
        logic [NUM_SRC-1:0] g;
        w = modelWinner();
        g = '0;
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    task automatic setChan(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        in_tag[ch*TAG_W +: TAG_W]   = t;
        in_val[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] req);
        in_request = req;
    endtask

    // Cross one rising edge: update the model and push what the bus must
    // show in the next cycle. A winner optionally drops its request after
    // the edge, as a functional unit would once its result is accepted.
    task automatic advance(input bit dropWinner);
        int   w;
        exp_t e;
        w = modelWinner();
        e = '0;
        @(posedge clk);
        if (!rst_n) begin
            ptrModel = 0;
            lastVal  = '0;
            errModel = 1'b0;
            e.tag    = INV;
        end else if (w < 0) begin
            e.tag = INV;
            e.val = lastVal;
        end else begin
            ptrModel = (w == NUM_SRC-1) ? 0 : w + 1;
            e.tag    = in_tag[w*TAG_W +: TAG_W];
            e.val    = in_val[w*DATA_W +: DATA_W];
`ifdef CDB_TAG_CHECK_EN
            if (e.tag == INV) begin
                errModel = 1'b1;
                e.val    = lastVal;
            end else begin
                e.bcast = 1'b1;
                lastVal = e.val;
            end
`else
            e.bcast = 1'b1;
            lastVal = e.val;
`endif
        end
        sbq.push_back(e);
        #1;
        if (dropWinner && w >= 0) in_request[w] = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        $display("[TB] test_reset");
        for (int c = 0; c < 5; c++) begin
            if (c == 1) applyStimulus(5'b11111);
            if (c == 4) begin
                applyStimulus(5'b00000);
                rst_n = 1'b1;
            end
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL reset_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL reset_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL reset_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
            advance(1'b0);
        end
    endtask

    task automatic test_single();
        exp_t e;
        $display("[TB] test_single");
        setChan(2, 5'd7, 32'hDEAD_BEEF);
        applyStimulus(5'b00100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL single_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL single_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL single_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
            advance(1'b1);
        end
    endtask

    task automatic test_all_channels();
        exp_t e;
        $display("[TB] test_all_channels");
        rst_n = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) setChan(i, TAG_W'(i + 10), 32'h1000_0000 + i);
        applyStimulus(5'b11111);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) rst_n = 1'b1;
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL all_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL all_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL all_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
            advance(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   w;
        $display("[TB] test_back_to_back");
        setChan(1, 5'd1, 32'h0000_0101);
        setChan(3, 5'd3, 32'h0000_0303);
        applyStimulus(5'b01010);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) applyStimulus(5'b00000);
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL b2b_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL b2b_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
            w = modelWinner();
            advance(1'b0);
            if (w >= 0) setChan(w, TAG_W'(w + 2*c + 4), 32'hC0DE_0000 + 32'(c*16 + w));
        end
    endtask

    task automatic test_wraparound();
        exp_t e;
        $display("[TB] test_wraparound");
        setChan(3, 5'd21, 32'h3333_0003);
        setChan(4, 5'd22, 32'h4444_0004);
        setChan(0, 5'd20, 32'h0000_0A0A);
        applyStimulus(5'b01000);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) applyStimulus(5'b10001);
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL wrap_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL wrap_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL wrap_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
            advance(1'b1);
        end
    endtask

    task automatic test_invalid_tag();
        exp_t e;
        $display("[TB] test_invalid_tag");
        setChan(1, INV, 32'h5555_AAAA);
        setChan(2, 5'd3, 32'h0000_3333);
        applyStimulus(5'b00010);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) applyStimulus(5'b00100);
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL inv_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL inv_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL inv_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
`ifdef CDB_TAG_CHECK_EN
            compared++;
            if (out_tag_err !== errModel) begin
                mismatched++;
                $display("[TB] FAIL inv_err c%0d: got %b expected %b", c, out_tag_err, errModel);
            end
`endif
            advance(1'b1);
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        $display("[TB] test_reset_midop");
        setChan(2, 5'd12, 32'h2222_0C0C);
        setChan(4, 5'd14, 32'h4444_0E0E);
        applyStimulus(5'b10100);
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) rst_n = 1'b1;
            @(negedge clk);
            compared++;
            if (out_grant !== modelGrant()) begin
                mismatched++;
                $display("[TB] FAIL midrst_grant c%0d: got %b expected %b", c, out_grant, modelGrant());
            end
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL midrst_bus c%0d: no expected entry", c);
            end else begin
                e = sbq.pop_front();
                if ({out_broadcast, out_tag, out_val} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL midrst_bus c%0d: got b=%b t=%h v=%h expected b=%b t=%h v=%h",
                             c, out_broadcast, out_tag, out_val, e.bcast, e.tag, e.val);
                end
            end
`ifdef CDB_TAG_CHECK_EN
            compared++;
            if (out_tag_err !== errModel) begin
                mismatched++;
                $display("[TB] FAIL midrst_err c%0d: got %b expected %b", c, out_tag_err, errModel);
            end
`endif
            advance(1'b1);
        end
    endtask

    // Test sequence; the first edge is crossed under reset so the scoreboard
    // always holds exactly one entry when a falling-edge check runs.
    initial begin
        rst_n      = 1'b0;
        in_request = '0;
        in_tag     = '0;
        in_val     = '0;
        advance(1'b0);
        test_reset();
        test_single();
        test_all_channels();
        test_back_to_back();
        test_wraparound();
        test_invalid_tag();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
